trg_pls_multi: RTL and testbench

Parametrised multi-channel trigger pulse generator, configured over a write-only SPI slave, sitting beside the Nios system on the DE0-Nano and driving the board's trigger pins. Each channel produces a programmable delay-then-pulse sequence, either one-shot or periodic, started by a global fire command. Channel count and counter width are parameters, replacing the fixed 5-output trigger component.

---
 rtl/trg_pls_pkg.sv | 33 +++
 rtl/trg_pls_spi_rx.sv | 70 +++++++
 rtl/trg_pls_multi.sv | 219 +++++++++++++++++++++
 tb/tb_trg_pls_multi.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pls_pkg.sv
// Shared types and constants for the multi-channel trigger pulse generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trg_pls_pkg;

    // Per-channel sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } trg_st_e;

    // Register index within a channel (low address nibble)
    localparam logic [3:0] REG_DELAY  = 4'd0;
    localparam logic [3:0] REG_WIDTH  = 4'd1;
    localparam logic [3:0] REG_PERIOD = 4'd2;
    localparam logic [3:0] REG_CTRL   = 4'd3;

    // Channel code addressing the global command register
    localparam logic [3:0] GLB_CH     = 4'hF;
    localparam logic [3:0] REG_GLB    = 4'd0;

    // CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PER_BIT = 1;
    localparam int CTRL_EXT_BIT = 2;

    // Global command bit positions
    localparam int GLB_FIRE_BIT = 0;
    localparam int GLB_STOP_BIT = 1;

endpackage

// File: rtl/trg_pls_spi_rx.sv
// Write-only SPI (mode 0) frame receiver: synchronises pins, shifts MSB first, strobes complete frames.
// Latency: frm_vld rises 3 clk_50 cycles after the spi_cs pin rises (2-flop sync + edge detect + register).
// Backpressure: none; frames with a bit count other than FRM_W are silently dropped.
module trg_pls_spi_rx #(
    parameter int FRM_W = 24
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             frm_vld,
    output logic [FRM_W-1:0] frm_dat
);

    localparam int              BC_W    = $clog2(FRM_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRM_W);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(FRM_W + 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    // [0] metastable stage, [1] synchronised, [2] previous synchronised value
    logic [2:0]       sclk_s;
    logic [2:0]       cs_s;
    logic [1:0]       mosi_s;
    logic [BC_W-1:0]  bit_cnt;
    logic [FRM_W-1:0] sh;
    logic             sclk_rise;
    logic             cs_rise;
    logic             cs_low;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign cs_low    = ~cs_s[1];
    assign frm_dat   = sh;

    // Pin synchronisers; cs idles high so reset cannot fake a frame end
    always_ff @(posedge clk_50) begin
        if (reset) begin
            sclk_s <= 3'b000;
            cs_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], spi_clk};
            cs_s   <= {cs_s[1:0], spi_cs};
            mosi_s <= {mosi_s[0], spi_mosi};
        end
    end

    // Shift on SCLK rise inside a frame; validate the bit count when cs releases
    always_ff @(posedge clk_50) begin
        if (reset) begin
            bit_cnt <= '0;
            sh      <= '0;
            frm_vld <= 1'b0;
        end else begin
            frm_vld <= 1'b0;
            if (cs_rise) begin
                frm_vld <= (bit_cnt == BC_FULL);
                bit_cnt <= '0;
            end else if (cs_low && sclk_rise) begin
                sh <= {sh[FRM_W-2:0], mosi_s[1]};
                // saturate just past a full frame so overlong frames never alias
                if (bit_cnt != BC_SAT) begin
                    bit_cnt <= bit_cnt + BC_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/trg_pls_multi.sv
// CH_N-channel delay-then-pulse trigger generator configured over SPI; TRG_PLS_EXT_TRIG_EN adds trg_in firing.
// Latency: command committed in cycle T takes effect at T+1; outputs are registered copies of the next state.
// Backpressure: none; FIRE retriggers busy channels, STOP overrides FIRE.
module trg_pls_multi
    import trg_pls_pkg::*;
#(
    parameter int CH_N  = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk_50,
    input  logic            reset,
    input  logic            spi_clk,
    input  logic            spi_cs,
    input  logic            spi_mosi,
`ifdef TRG_PLS_EXT_TRIG_EN
    input  logic            trg_in,
`endif
    output logic [CH_N-1:0] trg_pls_triggersignal,
    output logic [CH_N-1:0] trg_busy
);

    localparam int               FRM_W    = 8 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   PCNT_ONE = (CNT_W + 1)'(1);

    logic             frm_vld;
    logic [FRM_W-1:0] frm_dat;
    logic [3:0]       wr_ch;
    logic [3:0]       wr_reg;
    logic [CNT_W-1:0] wr_dat;
    logic             glb_wr;
    logic             stop_stb;
    logic             fire_stb;

    trg_pls_spi_rx #(.FRM_W(FRM_W)) u_spi_rx (
        .clk_50   (clk_50),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .frm_vld  (frm_vld),
        .frm_dat  (frm_dat)
    );

    assign wr_ch    = frm_dat[FRM_W-1 -: 4];
    assign wr_reg   = frm_dat[FRM_W-5 -: 4];
    assign wr_dat   = frm_dat[CNT_W-1:0];
    assign glb_wr   = frm_vld && (wr_ch == GLB_CH) && (wr_reg == REG_GLB);
    assign stop_stb = glb_wr & wr_dat[GLB_STOP_BIT];
    assign fire_stb = glb_wr & wr_dat[GLB_FIRE_BIT] & ~wr_dat[GLB_STOP_BIT];

`ifdef TRG_PLS_EXT_TRIG_EN
    logic [2:0] trg_s;
    logic       ext_fire;

    assign ext_fire = trg_s[1] & ~trg_s[2];

    // External trigger synchroniser plus previous value for rising-edge detect
    always_ff @(posedge clk_50) begin
        if (reset) begin
            trg_s <= 3'b000;
        end else begin
            trg_s <= {trg_s[1:0], trg_in};
        end
    end
`endif

    for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
        localparam logic [3:0] CH_ID = 4'(gi);

        logic [CNT_W-1:0] dly_r;
        logic [CNT_W-1:0] wid_r;
        logic [CNT_W-1:0] per_r;
        logic             en_r;
        logic             prd_r;
        logic             fire_req;
        logic [CNT_W:0]   wid_p1;
        logic [CNT_W:0]   per_x;
        logic [CNT_W:0]   eff_new;

        trg_st_e          st_q, st_n;
        logic [CNT_W-1:0] cnt_q, cnt_n;    // cycles left in DELAY or PULSE
        logic [CNT_W:0]   pcnt_q, pcnt_n;  // cycles since PULSE entry, 1 in the entry cycle
        logic [CNT_W:0]   eff_q, eff_n;    // effective period latched at PULSE entry
        logic             enter_pulse;
        logic             pls_q;
        logic             busy_q;

`ifdef TRG_PLS_EXT_TRIG_EN
        logic ext_en_r;

        // Configuration registers, written by complete frames addressed to this channel
        always_ff @(posedge clk_50) begin
            if (reset) begin
                dly_r    <= '0;
                wid_r    <= CNT_ONE;
                per_r    <= '0;
                en_r     <= 1'b0;
                prd_r    <= 1'b0;
                ext_en_r <= 1'b0;
            end else if (frm_vld && (wr_ch == CH_ID)) begin
                case (wr_reg)
                    REG_DELAY:  dly_r <= wr_dat;
                    REG_WIDTH:  wid_r <= wr_dat;
                    REG_PERIOD: per_r <= wr_dat;
                    REG_CTRL: begin
                        en_r     <= wr_dat[CTRL_EN_BIT];
                        prd_r    <= wr_dat[CTRL_PER_BIT];
                        ext_en_r <= wr_dat[CTRL_EXT_BIT];
                    end
                    default: ;
                endcase
            end
        end

        assign fire_req = en_r & (fire_stb | (ext_fire & ext_en_r));
`else
        // Configuration registers, written by complete frames addressed to this channel
        always_ff @(posedge clk_50) begin
            if (reset) begin
                dly_r <= '0;
                wid_r <= CNT_ONE;
                per_r <= '0;
                en_r  <= 1'b0;
                prd_r <= 1'b0;
            end else if (frm_vld && (wr_ch == CH_ID)) begin
                case (wr_reg)
                    REG_DELAY:  dly_r <= wr_dat;
                    REG_WIDTH:  wid_r <= wr_dat;
                    REG_PERIOD: per_r <= wr_dat;
                    REG_CTRL: begin
                        en_r  <= wr_dat[CTRL_EN_BIT];
                        prd_r <= wr_dat[CTRL_PER_BIT];
                    end
                    default: ;
                endcase
            end
        end

        assign fire_req = en_r & fire_stb;
`endif

        // Period can never be shorter than the pulse plus one low cycle; one extra bit avoids wrap
        assign wid_p1  = {1'b0, wid_r} + PCNT_ONE;
        assign per_x   = {1'b0, per_r};
        assign eff_new = (per_x > wid_p1) ? per_x : wid_p1;

        // Next-state: STOP beats FIRE, FIRE beats the running sequence
        always_comb begin
            st_n        = st_q;
            cnt_n       = cnt_q;
            pcnt_n      = pcnt_q;
            eff_n       = eff_q;
            enter_pulse = 1'b0;
            if (stop_stb) begin
                st_n = ST_IDLE;
            end else if (fire_req) begin
                if (dly_r != '0) begin
                    st_n  = ST_DELAY;
                    cnt_n = dly_r;
                end else begin
                    enter_pulse = 1'b1;
                end
            end else begin
                case (st_q)
                    ST_IDLE: ;
                    ST_DELAY: begin
                        if (cnt_q == CNT_ONE) enter_pulse = 1'b1;
                        else                  cnt_n = cnt_q - CNT_ONE;
                    end
                    ST_PULSE: begin
                        pcnt_n = pcnt_q + PCNT_ONE;
                        if (cnt_q == CNT_ONE) st_n  = prd_r ? ST_GAP : ST_IDLE;
                        else                  cnt_n = cnt_q - CNT_ONE;
                    end
                    ST_GAP: begin
                        if (pcnt_q == eff_q) enter_pulse = 1'b1;
                        else                 pcnt_n = pcnt_q + PCNT_ONE;
                    end
                    default: ;
                endcase
            end
            // PULSE entry samples WIDTH/PERIOD; a zero width skips straight past the pulse
            if (enter_pulse) begin
                eff_n  = eff_new;
                pcnt_n = PCNT_ONE;
                if (wid_r != '0) begin
                    st_n  = ST_PULSE;
                    cnt_n = wid_r;
                end else begin
                    st_n = prd_r ? ST_GAP : ST_IDLE;
                end
            end
        end

        // State register with registered pulse and busy outputs
        always_ff @(posedge clk_50) begin
            if (reset) begin
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                pcnt_q <= '0;
                eff_q  <= '0;
                pls_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                st_q   <= st_n;
                cnt_q  <= cnt_n;
                pcnt_q <= pcnt_n;
                eff_q  <= eff_n;
                pls_q  <= (st_n == ST_PULSE);
                busy_q <= (st_n != ST_IDLE);
            end
        end

        assign trg_pls_triggersignal[gi] = pls_q;
        assign trg_busy[gi]              = busy_q;
    end

endmodule

// File: tb/tb_trg_pls_multi.sv
// Self-checking bench for trg_pls_multi: SPI bit-banged writes, per-cycle comparison against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_trg_pls_multi;

    localparam int     CH_N  = 5;
    localparam int     CNT_W = 16;
    localparam int     FRM_W = 8 + CNT_W;
    localparam int     HB    = 4;  // clk_50 cycles per SPI half bit
    localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

    logic            clk_50   = 1'b0;
    logic            reset    = 1'b1;
    logic            spi_clk  = 1'b0;
    logic            spi_cs   = 1'b1;
    logic            spi_mosi = 1'b0;
`ifdef TRG_PLS_EXT_TRIG_EN
    logic            trg_in   = 1'b0;
`endif
    logic [CH_N-1:0] trg_pls_triggersignal;
    logic [CH_N-1:0] trg_busy;

    trg_pls_multi #(.CH_N(CH_N), .CNT_W(CNT_W)) dut (
        .clk_50                (clk_50),
        .reset                 (reset),
        .spi_clk               (spi_clk),
        .spi_cs                (spi_cs),
        .spi_mosi              (spi_mosi),
`ifdef TRG_PLS_EXT_TRIG_EN
        .trg_in                (trg_in),
`endif
        .trg_pls_triggersignal (trg_pls_triggersignal),
        .trg_busy              (trg_busy)
    );

    always #10 clk_50 = ~clk_50;

    // Index of the current clock cycle (cycle k starts at the k-th rising edge)
    longint cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is one FIRE: starts at cycle s, forced off at cycle e.
    typedef struct {
        bit     act;
        longint s;
        longint e;
        longint d;
        longint w;
        longint eff;
        bit     per;
    } run_t;

    run_t   cur [CH_N];
    run_t   prv [CH_N];
    longint m_dly [CH_N];
    longint m_wid [CH_N];
    longint m_per [CH_N];
    bit     m_en  [CH_N];
    bit     m_prd [CH_N];

    function automatic void eval(input run_t r, input longint c, output bit p, output bit b);
        longint rel;
        p = 1'b0;
        b = 1'b0;
        if (r.act && c >= r.s && c < r.e) begin
            rel = c - r.s - r.d;
            if (r.per) begin
                b = 1'b1;
                p = (rel >= 0) && ((rel % r.eff) < r.w);
            end else begin
                b = (rel < r.w);
                p = (rel >= 0) && (rel < r.w);
            end
        end
    endfunction

    task automatic model_reset(input longint at);
        for (int i = 0; i < CH_N; i++) begin
            if (cur[i].e > at) cur[i].e = at;
            if (prv[i].e > at) prv[i].e = at;
            m_dly[i] = 0;
            m_wid[i] = 1;
            m_per[i] = 0;
            m_en[i]  = 1'b0;
            m_prd[i] = 1'b0;
        end
    endtask

    task automatic model_apply(input logic [7:0] addr, input logic [CNT_W-1:0] data, input longint t);
        int ch;
        int rg;
        ch = int'(addr[7:4]);
        rg = int'(addr[3:0]);
        if (ch < CH_N) begin
            case (rg)
                0: m_dly[ch] = longint'(data);
                1: m_wid[ch] = longint'(data);
                2: m_per[ch] = longint'(data);
                3: begin m_en[ch] = data[0]; m_prd[ch] = data[1]; end
                default: ;
            endcase
        end else if (ch == 15 && rg == 0) begin
            if (data[1]) begin
                for (int i = 0; i < CH_N; i++)
                    if (cur[i].e > t + 1) cur[i].e = t + 1;
            end else if (data[0]) begin
                for (int i = 0; i < CH_N; i++) begin
                    if (m_en[i]) begin
                        prv[i] = cur[i];
                        if (prv[i].e > t + 1) prv[i].e = t + 1;
                        cur[i] = '{act: 1'b1, s: t + 1, e: NEVER, d: m_dly[i], w: m_wid[i],
                                   eff: (m_per[i] > m_wid[i] + 1) ? m_per[i] : m_wid[i] + 1,
                                   per: m_prd[i]};
                    end
                end
            end
        end
    endtask

    // Per-cycle comparison of both output vectors against the model
    bit              chk_on = 1'b0;
    logic [CH_N-1:0] ep;
    logic [CH_N-1:0] eb;
    bit              mp;
    bit              mb;
    always @(negedge clk_50) begin
        if (chk_on) begin
            for (int i = 0; i < CH_N; i++) begin
                if (cyc >= cur[i].s) eval(cur[i], cyc, mp, mb);
                else                 eval(prv[i], cyc, mp, mb);
                ep[i] = mp;
                eb[i] = mb;
            end
            chk("pls_vec", 32'(trg_pls_triggersignal), 32'(ep));
            chk("busy_vec", 32'(trg_busy), 32'(eb));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Sends word[nb-1:0] MSB first; t is the commit cycle of the frame
    task automatic spi_xfer(input logic [39:0] word, input int nb, output longint t);
        repeat (HB) @(negedge clk_50);
        spi_cs = 1'b0;
        repeat (HB) @(negedge clk_50);
        for (int i = nb - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            repeat (HB) @(negedge clk_50);
            spi_clk = 1'b1;
            repeat (HB) @(negedge clk_50);
            spi_clk = 1'b0;
        end
        repeat (HB) @(negedge clk_50);
        spi_cs = 1'b1;
        t = cyc + 3;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [CNT_W-1:0] data, output longint t);
        spi_xfer({16'h0, addr, data}, FRM_W, t);
        model_apply(addr, data, t);
    endtask

    task automatic wait_to(input longint t);
        while (cyc < t) @(negedge clk_50);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    longint t;
    longint t2;
    logic [7:0] a;

    initial begin
        model_reset(0);
        repeat (3) @(negedge clk_50);
        chk("rst_pls", 32'(trg_pls_triggersignal), 32'd0);
        chk("rst_busy", 32'(trg_busy), 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;

        // ch0 one-shot: DELAY 3, WIDTH 4
        do_write(8'h00, 16'd3, t);
        do_write(8'h01, 16'd4, t);
        do_write(8'h03, 16'd1, t);
        do_write(8'hF0, 16'd1, t);
        wait_to(t + 1); chk("A_busy_rise", 32'(trg_busy[0]), 32'd1);
        wait_to(t + 3); chk("A_low_T3", 32'(trg_pls_triggersignal[0]), 32'd0);
        wait_to(t + 4); chk("A_high_T4", 32'(trg_pls_triggersignal[0]), 32'd1);
        wait_to(t + 7); chk("A_high_T7", 32'(trg_pls_triggersignal[0]), 32'd1);
                        chk("A_busy_T7", 32'(trg_busy[0]), 32'd1);
        wait_to(t + 8); chk("A_low_T8", 32'(trg_pls_triggersignal[0]), 32'd0);
                        chk("A_idle_T8", 32'(trg_busy[0]), 32'd0);

        // ch1 periodic 2/10, ch2 periodic 5/3 (clamps to 6)
        do_write(8'h11, 16'd2, t);
        do_write(8'h12, 16'd10, t);
        do_write(8'h13, 16'd3, t);
        do_write(8'h21, 16'd5, t);
        do_write(8'h22, 16'd3, t);
        do_write(8'h23, 16'd3, t);
        do_write(8'hF0, 16'd1, t);
        wait_to(t + 1);  chk("B1_rise0", 32'(trg_pls_triggersignal[1]), 32'd1);
        wait_to(t + 6);  chk("B2_gap", 32'(trg_pls_triggersignal[2]), 32'd0);
        wait_to(t + 7);  chk("B2_rise1", 32'(trg_pls_triggersignal[2]), 32'd1);
        wait_to(t + 10); chk("B1_gap_end", 32'(trg_pls_triggersignal[1]), 32'd0);
        wait_to(t + 11); chk("B1_rise1", 32'(trg_pls_triggersignal[1]), 32'd1);
        wait_to(t + 100);
        do_write(8'hF0, 16'd2, t);
        wait_to(t + 1);
        chk("B_stop_pls", 32'(trg_pls_triggersignal), 32'd0);
        chk("B_stop_busy", 32'(trg_busy), 32'd0);

        // Short and long frames to ch3 CTRL must be dropped; ignored addresses too
        spi_xfer(40'h00_0033_0001, FRM_W + 1, t);
        spi_xfer(40'h00_0033_0001, FRM_W - 1, t);
        do_write(8'h73, 16'd1, t);
        do_write(8'hF1, 16'd1, t);
        do_write(8'hF0, 16'd1, t);
        wait_to(t + 2);
        chk("C_ch3_idle", 32'(trg_busy[3]), 32'd0);
        wait_to(t + 60);
        do_write(8'hF0, 16'd2, t);

        // Retrigger mid-pulse, then FIRE|STOP in one write
        do_write(8'h00, 16'd5, t);
        do_write(8'h01, 16'd250, t);
        do_write(8'hF0, 16'd1, t);
        do_write(8'hF0, 16'd1, t2);
        wait_to(t2);     chk("D_mid_pulse", 32'(trg_pls_triggersignal[0]), 32'd1);
        wait_to(t2 + 1); chk("D_retrig_low", 32'(trg_pls_triggersignal[0]), 32'd0);
                         chk("D_retrig_busy", 32'(trg_busy[0]), 32'd1);
        wait_to(t2 + 6); chk("D_retrig_high", 32'(trg_pls_triggersignal[0]), 32'd1);
        do_write(8'hF0, 16'd3, t);
        wait_to(t + 1);
        chk("D_firestop_pls", 32'(trg_pls_triggersignal), 32'd0);
        chk("D_firestop_busy", 32'(trg_busy), 32'd0);

        // Reset in the middle of a pulse, then FIRE with everything disabled
        do_write(8'hF0, 16'd1, t);
        wait_to(t + 30);
        reset = 1'b1;
        model_reset(cyc + 1);
        @(negedge clk_50);
        chk("E_rst_pls", 32'(trg_pls_triggersignal), 32'd0);
        chk("E_rst_busy", 32'(trg_busy), 32'd0);
        repeat (2) @(negedge clk_50);
        reset = 1'b0;
        do_write(8'hF0, 16'd1, t);
        wait_to(t + 2);
        chk("E_noen_busy", 32'(trg_busy), 32'd0);
        wait_to(t + 40);

        // Randomised configurations, fire, optional retrigger, stop
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < CH_N; c++) begin
                a = {4'(c), 4'h0};
                do_write(a,        16'($urandom_range(0, 6)),  t);
                do_write(a | 8'h1, 16'($urandom_range(0, 6)),  t);
                do_write(a | 8'h2, 16'($urandom_range(0, 16)), t);
                do_write(a | 8'h3, 16'($urandom_range(0, 3)),  t);
            end
            do_write(8'hF0, 16'd1, t);
            repeat ($urandom_range(20, 150)) @(negedge clk_50);
            if ($urandom_range(0, 1) == 1) begin
                do_write(8'hF0, 16'd1, t);
                repeat ($urandom_range(5, 80)) @(negedge clk_50);
            end
            do_write(8'hF0, 16'($urandom_range(2, 3)), t);
            wait_to(t + 5);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
